// File: rtl/pixel_write_sink_pkg.sv
// Shared configuration, pixel-entry layout and drain FSM states
// for the painter pixel-write sink.
package pixel_write_sink_pkg;

    localparam int SCR_WIDTH  = 160;
    localparam int SCR_HEIGHT = 120;
    localparam int X_BITS     = 8;
    localparam int Y_BITS     = 7;
    localparam int COLOR_BITS = 3;
    localparam int ADDR_BITS  = 15;
    localparam int FIFO_DEPTH = 4;
    localparam int DROP_BITS  = 8;

    typedef struct packed {
        logic [X_BITS-1:0]     x;
        logic [Y_BITS-1:0]     y;
        logic [COLOR_BITS-1:0] color;
    } pixel_t;

    localparam int ENTRY_BITS = $bits(pixel_t);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } drain_state_e;

    function automatic logic in_screen(input pixel_t p);
        return (int'(p.x) < SCR_WIDTH) && (int'(p.y) < SCR_HEIGHT);
    endfunction

    // Row-major address; intermediates kept at ADDR_BITS so in-range
    // coordinates never truncate.
    function automatic logic [ADDR_BITS-1:0] pixel_addr(input pixel_t p);
        return ADDR_BITS'(p.y) * ADDR_BITS'(SCR_WIDTH) + ADDR_BITS'(p.x);
    endfunction

endpackage

// File: rtl/pixel_write_sink_if.sv
// Painter-side and frame-buffer-side signal bundle of the pixel sink.
// slave: the sink itself; master: painter / memory side.
interface pixel_write_sink_if;
    import pixel_write_sink_pkg::*;

    logic [X_BITS-1:0]     pix_x;
    logic [Y_BITS-1:0]     pix_y;
    logic [COLOR_BITS-1:0] pix_color;
    logic                  print_enable;
    logic [ADDR_BITS-1:0]  mem_addr;
    logic [COLOR_BITS-1:0] mem_data;
    logic                  mem_we;
    logic                  mem_ack;
    logic                  fifo_full;
    logic                  overflow;
    logic [DROP_BITS-1:0]  drop_count;
    logic                  busy;

    modport slave (
        input  pix_x, pix_y, pix_color, print_enable, mem_ack,
        output mem_addr, mem_data, mem_we,
        output fifo_full, overflow, drop_count, busy
    );

    modport master (
        output pix_x, pix_y, pix_color, print_enable, mem_ack,
        input  mem_addr, mem_data, mem_we,
        input  fifo_full, overflow, drop_count, busy
    );

endinterface

// File: rtl/pixel_fifo.sv
// Synchronous FIFO with occupancy count; power-of-two depth so the
// read/write pointers wrap naturally.
module pixel_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign rdata   = mem_q[rd_q];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (do_push) begin
            mem_d[wr_q] = wdata;
            wr_d        = wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = rd_q + 1'b1;
        end
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pixel_write_sink.sv
// Painter pixel-write sink: strobe detect, range check, FIFO, RAM drain.
// Optional PIXEL_WRITE_SINK_DEDUP_EN drops repeats of the last accepted pixel.
module pixel_write_sink
    import pixel_write_sink_pkg::*;
(
    input logic               Clck,
    input logic               Reset,
    pixel_write_sink_if.slave bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                  pe_q, pe_d;
    logic                  evt;
    pixel_t                cur;
    pixel_t                head;
    logic                  in_rng;
    logic                  dup;
    logic                  push_req;
    logic                  push;
    logic                  pop;
    logic                  ovf_drop;
    logic                  rng_drop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_cnt;
    logic [CW-1:0]         cnt_nxt;

    drain_state_e          st_q, st_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic [COLOR_BITS-1:0] data_q, data_d;
    logic                  we_q, we_d;
    logic                  ovf_q, ovf_d;
    logic [DROP_BITS-1:0]  drop_q, drop_d;
    logic                  busy_q, busy_d;

    assign cur = '{x: bus.pix_x, y: bus.pix_y, color: bus.pix_color};
    assign evt = bus.print_enable & ~pe_q;
    assign in_rng = in_screen(cur);

`ifdef PIXEL_WRITE_SINK_DEDUP_EN
    pixel_t last_q, last_d;
    logic   last_vld_q, last_vld_d;

    assign dup = last_vld_q && (cur == last_q);

    always_comb begin
        last_d     = last_q;
        last_vld_d = last_vld_q;
        if (push) begin
            last_d     = cur;
            last_vld_d = 1'b1;
        end
    end

    always_ff @(posedge Clck) begin
        if (Reset) begin
            last_q     <= '0;
            last_vld_q <= 1'b0;
        end else begin
            last_q     <= last_d;
            last_vld_q <= last_vld_d;
        end
    end
`else
    assign dup = 1'b0;
`endif

    // A full FIFO still accepts a push when the drain pops the same cycle.
    assign pop      = (st_q == ST_IDLE) & ~fifo_empty;
    assign push_req = evt & in_rng & ~dup;
    assign push     = push_req & (~fifo_full | pop);
    assign ovf_drop = push_req & fifo_full & ~pop;
    assign rng_drop = evt & ~in_rng;
    assign cnt_nxt  = fifo_cnt + CW'(push) - CW'(pop);

    pixel_fifo #(
        .WIDTH (ENTRY_BITS),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (Clck),
        .rst   (Reset),
        .push  (push),
        .pop   (pop),
        .wdata (cur),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    always_comb begin
        st_d   = st_q;
        addr_d = addr_q;
        data_d = data_q;
        we_d   = we_q;
        unique case (st_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    addr_d = pixel_addr(head);
                    data_d = head.color;
                    we_d   = 1'b1;
                    st_d   = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (bus.mem_ack) begin
                    we_d = 1'b0;
                    st_d = ST_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        pe_d   = bus.print_enable;
        ovf_d  = ovf_q | ovf_drop;
        drop_d = drop_q;
        if ((ovf_drop | rng_drop) && (drop_q != '1)) begin
            drop_d = drop_q + 1'b1;
        end
        busy_d = (cnt_nxt != '0) | we_d;
    end

    always_ff @(posedge Clck) begin
        if (Reset) begin
            pe_q   <= 1'b0;
            st_q   <= ST_IDLE;
            addr_q <= '0;
            data_q <= '0;
            we_q   <= 1'b0;
            ovf_q  <= 1'b0;
            drop_q <= '0;
            busy_q <= 1'b0;
        end else begin
            pe_q   <= pe_d;
            st_q   <= st_d;
            addr_q <= addr_d;
            data_q <= data_d;
            we_q   <= we_d;
            ovf_q  <= ovf_d;
            drop_q <= drop_d;
            busy_q <= busy_d;
        end
    end

    assign bus.mem_addr   = addr_q;
    assign bus.mem_data   = data_q;
    assign bus.mem_we     = we_q;
    assign bus.fifo_full  = fifo_full;
    assign bus.overflow   = ovf_q;
    assign bus.drop_count = drop_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_pixel_write_sink.sv
// Self-checking bench for pixel_write_sink: vector table, hand-written
// corner sequences and a randomized run against a queue-based model.
module tb_pixel_write_sink;
    import pixel_write_sink_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pixel_write_sink_if bus ();

    pixel_write_sink dut (
        .Clck  (clk),
        .Reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    typedef struct {
        int x;
        int y;
        int c;
        bit wr;
        int addr;
    } vec_t;

    int  checks = 0;
    int  errors = 0;
    int  ack_mode = 0;
    int  we_age = 0;
    wr_t obs[$];
    wr_t exp_q[$];
    vec_t vt[10];

    // ack driver: 0 low, 1 high, 2 random but bounded, 3 manual
    initial forever begin
        @(posedge clk);
        #2;
        we_age = bus.mem_we ? we_age + 1 : 0;
        case (ack_mode)
            0: bus.mem_ack = 1'b0;
            1: bus.mem_ack = 1'b1;
            2: bus.mem_ack = (we_age >= 2) ? 1'b1 : 1'($urandom % 2);
            default: ;
        endcase
    end

    initial forever begin
        @(negedge clk);
        if (!rst && bus.mem_we && bus.mem_ack)
            obs.push_back('{int'(bus.mem_addr), int'(bus.mem_data)});
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_pix(input int x, input int y, input int c);
        bus.pix_x     = X_BITS'(x);
        bus.pix_y     = Y_BITS'(y);
        bus.pix_color = COLOR_BITS'(c);
    endtask

    task automatic strobe(input int x, input int y, input int c,
                          input int hold, input int gap);
        set_pix(x, y, c);
        bus.print_enable = 1'b1;
        tick(hold);
        bus.print_enable = 1'b0;
        tick(gap);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.print_enable = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic check_writes(input string nm);
        int n;
        chk({nm, " write count"}, obs.size(), exp_q.size());
        n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({nm, " addr"}, obs[i].addr, exp_q[i].addr);
            chk({nm, " data"}, obs[i].data, exp_q[i].data);
        end
        obs.delete();
        exp_q.delete();
    endtask

    initial begin
        int exp_drop;
        int x, y, c, hold, gap;
        int lx, ly, lc;
        bit lvld;

        vt[0] = '{5,   2,   6, 1'b1, 325};
        vt[1] = '{160, 0,   2, 1'b0, 0};
        vt[2] = '{159, 119, 5, 1'b1, 19199};
        vt[3] = '{0,   0,   7, 1'b1, 0};
        vt[4] = '{7,   7,   1, 1'b1, 1127};
        vt[5] = '{0,   120, 3, 1'b0, 0};
        vt[6] = '{159, 0,   4, 1'b1, 159};
        vt[7] = '{0,   119, 2, 1'b1, 19040};
        vt[8] = '{255, 127, 1, 1'b0, 0};
        vt[9] = '{3,   100, 0, 1'b1, 16003};

        bus.print_enable = 1'b0;
        bus.mem_ack = 1'b0;
        set_pix(0, 0, 0);
        ack_mode = 3;

        // reset state
        do_reset();
        chk("rst mem_we", int'(bus.mem_we), 0);
        chk("rst mem_addr", int'(bus.mem_addr), 0);
        chk("rst mem_data", int'(bus.mem_data), 0);
        chk("rst fifo_full", int'(bus.fifo_full), 0);
        chk("rst overflow", int'(bus.overflow), 0);
        chk("rst drop_count", int'(bus.drop_count), 0);
        chk("rst busy", int'(bus.busy), 0);

        // single pixel, 3-cycle strobe, slow ack
        set_pix(5, 2, 6);
        bus.print_enable = 1'b1;
        tick();
        chk("a we after event", int'(bus.mem_we), 0);
        chk("a busy after event", int'(bus.busy), 1);
        tick();
        chk("a we latency", int'(bus.mem_we), 1);
        chk("a addr", int'(bus.mem_addr), 325);
        chk("a data", int'(bus.mem_data), 6);
        tick();
        bus.print_enable = 1'b0;
        tick(3);
        chk("a we held", int'(bus.mem_we), 1);
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        chk("a we after ack", int'(bus.mem_we), 0);
        tick(4);
        chk("a busy idle", int'(bus.busy), 0);
        chk("a we stays low", int'(bus.mem_we), 0);
        exp_q.push_back('{325, 6});
        check_writes("a");

        // strobe already high when reset releases
        ack_mode = 1;
        rst = 1'b1;
        set_pix(7, 7, 1);
        bus.print_enable = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
        bus.print_enable = 1'b0;
        tick(6);
        exp_q.push_back('{1127, 1});
        check_writes("rel");
        chk("rel drop", int'(bus.drop_count), 0);

        // vector table
        do_reset();
        exp_drop = 0;
        for (int i = 0; i < 10; i++) begin
            strobe(vt[i].x, vt[i].y, vt[i].c, 3, 5);
            tick(4);
            if (vt[i].wr) exp_q.push_back('{vt[i].addr, vt[i].c});
            else exp_drop++;
            check_writes($sformatf("vec%0d", i));
            chk($sformatf("vec%0d drop", i), int'(bus.drop_count), exp_drop);
            chk($sformatf("vec%0d ovf", i), int'(bus.overflow), 0);
        end

        // duplicate pixels
        do_reset();
        strobe(7, 7, 1, 3, 5);
        strobe(7, 7, 1, 3, 5);
        tick(4);
        exp_q.push_back('{1127, 1});
`ifndef PIXEL_WRITE_SINK_DEDUP_EN
        exp_q.push_back('{1127, 1});
`endif
        check_writes("dup");
        chk("dup drop", int'(bus.drop_count), 0);

        // overflow with ack held low
        do_reset();
        ack_mode = 0;
        for (int i = 0; i < 5; i++) strobe(10 + i, 20 + i, i, 2, 2);
        chk("ovf full", int'(bus.fifo_full), 1);
        chk("ovf not yet", int'(bus.overflow), 0);
        chk("ovf drop pre", int'(bus.drop_count), 0);
        chk("ovf we", int'(bus.mem_we), 1);
        chk("ovf head addr", int'(bus.mem_addr), 3210);
        strobe(15, 25, 5, 2, 2);
        chk("ovf sticky", int'(bus.overflow), 1);
        chk("ovf drop", int'(bus.drop_count), 1);
        chk("ovf full2", int'(bus.fifo_full), 1);
        ack_mode = 1;
        tick(15);
        for (int i = 0; i < 5; i++)
            exp_q.push_back('{(20 + i) * 160 + 10 + i, i});
        check_writes("ovf");
        chk("ovf drained full", int'(bus.fifo_full), 0);
        chk("ovf drained busy", int'(bus.busy), 0);
        chk("ovf remains", int'(bus.overflow), 1);

        // reset in the middle of a handshake
        ack_mode = 0;
        strobe(1, 1, 2, 2, 2);
        strobe(2, 2, 3, 2, 2);
        chk("mid we", int'(bus.mem_we), 1);
        chk("mid busy", int'(bus.busy), 1);
        ack_mode = 3;
        bus.mem_ack = 1'b1;
        rst = 1'b1;
        tick();
        chk("mid rst we", int'(bus.mem_we), 0);
        chk("mid rst busy", int'(bus.busy), 0);
        chk("mid rst full", int'(bus.fifo_full), 0);
        chk("mid rst drop", int'(bus.drop_count), 0);
        chk("mid rst ovf", int'(bus.overflow), 0);
        tick();
        rst = 1'b0;
        tick(4);
        bus.mem_ack = 1'b0;
        chk("mid after we", int'(bus.mem_we), 0);
        check_writes("mid");

        // drop_count saturation
        do_reset();
        ack_mode = 1;
        for (int i = 0; i < 260; i++) strobe(200, 0, 0, 1, 1);
        chk("sat drop", int'(bus.drop_count), 255);
        chk("sat ovf", int'(bus.overflow), 0);
        check_writes("sat");

        // randomized run against the model
        do_reset();
        ack_mode = 2;
        exp_drop = 0;
        lvld = 1'b0;
        lx = 0;
        ly = 0;
        lc = 0;
        x = 0;
        y = 0;
        c = 0;
        for (int k = 0; k < 200; k++) begin
            if (k == 0 || ($urandom % 8) != 0) begin
                x = $urandom_range(0, 175);
                y = $urandom_range(0, 127);
                c = $urandom_range(0, 7);
            end
            hold = $urandom_range(1, 3);
            gap = $urandom_range(1, 3);
            if (hold + gap < 4) gap = 4 - hold;
            if (x < SCR_WIDTH && y < SCR_HEIGHT) begin
`ifdef PIXEL_WRITE_SINK_DEDUP_EN
                if (!(lvld && x == lx && y == ly && c == lc)) begin
                    exp_q.push_back('{y * SCR_WIDTH + x, c});
                    lvld = 1'b1;
                    lx = x;
                    ly = y;
                    lc = c;
                end
`else
                exp_q.push_back('{y * SCR_WIDTH + x, c});
`endif
            end else begin
                exp_drop++;
            end
            strobe(x, y, c, hold, gap);
        end
        tick(10);
        check_writes("rand");
        chk("rand drop", int'(bus.drop_count), (exp_drop > 255) ? 255 : exp_drop);
        chk("rand ovf", int'(bus.overflow), 0);
        chk("rand busy", int'(bus.busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
